rgb_stream_packer: RTL and testbench

RGB_STREAM_PACKER -- requirements
Module: rgb_stream_packer

---
 rtl/rgb_stream_packer.sv | 165 ++++++++++++++++
 tb/tb_rgb_stream_packer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels (b,g,r byte order) into a 32-bit little-endian byte stream
// with end-of-line flush, start-of-frame realignment and a small output FIFO.
module rgb_stream_packer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 2;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  typedef struct packed {
    logic        user;
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  phase_t        r_phase, w_phase_nxt, w_eff;
  logic [23:0]   r_res, w_res_nxt;
  logic          r_user_pend, w_user_pend_nxt, w_user;
  logic          r_run;
  word_t         r_stg0, r_stg1, w_w0, w_w1;
  logic [1:0]    r_stg_cnt, w_n;
  word_t         r_mem [FIFO_DEPTH];
  word_t         w_head;
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, w_occ;
  logic          w_accept, w_pop;
  logic [23:0]   w_pix;

  assign w_pix    = {r, g, b};
  // Staged words land in the FIFO next edge, so they count as occupancy now.
  assign w_occ    = r_cnt + CW'(r_stg_cnt);
  assign in_stream_ready   = r_run && (w_occ <= CW'(FIFO_DEPTH - 2));
  assign w_accept          = valid && in_stream_ready;
  assign out_stream_tvalid = (r_cnt != '0);
  assign w_pop             = out_stream_tvalid && out_stream_tready;

  always_comb begin
    w_phase_nxt     = r_phase;
    w_res_nxt       = r_res;
    w_user_pend_nxt = r_user_pend;
    w_w0            = '0;
    w_w1            = '0;
    w_n             = 2'd0;
    w_eff           = sof ? PH0 : r_phase;
    w_user          = sof | r_user_pend;
    if (w_accept) begin
      unique case (w_eff)
        PH0: begin
          w_res_nxt = w_pix;
          if (eol) begin
            w_w0.data   = {8'h00, w_pix};
            w_w0.keep   = 4'h7;
            w_w0.last   = 1'b1;
            w_n         = 2'd1;
            w_phase_nxt = PH0;
          end else begin
            w_phase_nxt = PH1;
          end
        end
        PH1: begin
          w_w0.data = {w_pix[7:0], r_res};
          w_w0.keep = 4'hF;
          w_n       = 2'd1;
          w_res_nxt = {8'h00, w_pix[23:8]};
          if (eol) begin
            w_w1.data   = {16'h0000, w_pix[23:8]};
            w_w1.keep   = 4'h3;
            w_w1.last   = 1'b1;
            w_n         = 2'd2;
            w_phase_nxt = PH0;
          end else begin
            w_phase_nxt = PH2;
          end
        end
        PH2: begin
          w_w0.data = {w_pix[15:0], r_res[15:0]};
          w_w0.keep = 4'hF;
          w_n       = 2'd1;
          w_res_nxt = {16'h0000, w_pix[23:16]};
          if (eol) begin
            w_w1.data   = {24'h000000, w_pix[23:16]};
            w_w1.keep   = 4'h1;
            w_w1.last   = 1'b1;
            w_n         = 2'd2;
            w_phase_nxt = PH0;
          end else begin
            w_phase_nxt = PH3;
          end
        end
        PH3: begin
          w_w0.data   = {w_pix, r_res[7:0]};
          w_w0.keep   = 4'hF;
          w_w0.last   = eol;
          w_n         = 2'd1;
          w_phase_nxt = PH0;
        end
      endcase
      w_w0.user       = w_user && (w_n != 2'd0);
      w_user_pend_nxt = w_user && (w_n == 2'd0);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_phase     <= PH0;
      r_res       <= '0;
      r_user_pend <= 1'b0;
      r_run       <= 1'b0;
      r_stg_cnt   <= '0;
      r_stg0      <= '0;
      r_stg1      <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_res       <= w_res_nxt;
      r_user_pend <= w_user_pend_nxt;
      r_run       <= 1'b1;
      r_stg_cnt   <= w_n;
      r_stg0      <= w_w0;
      r_stg1      <= w_w1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(r_stg_cnt);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + CW'(r_stg_cnt) - CW'(w_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (r_stg_cnt != 2'd0) r_mem[r_wp] <= r_stg0;
    if (r_stg_cnt == 2'd2) r_mem[r_wp + AW'(1)] <= r_stg1;
  end

  assign w_head           = r_mem[r_rp];
  assign out_stream_tdata = out_stream_tvalid ? w_head.data : '0;
  assign out_stream_tkeep = out_stream_tvalid ? w_head.keep : '0;
  assign out_stream_tlast = out_stream_tvalid && w_head.last;
  assign out_stream_tuser = out_stream_tvalid && w_head.user;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Bench for rgb_stream_packer: directed vector table, scaled frame, backpressure,
// async reset and randomized traffic checked against a byte-queue reference model.
module tb_rgb_stream_packer;
  localparam int unsigned DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol, ready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;

  always #5 aclk = ~aclk;

  rgb_stream_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b),
    .valid(valid), .sof(sof), .eol(eol), .in_stream_ready(ready),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
    .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready)
  );

  int unsigned errors = 0, checks = 0;
  int unsigned cyc = 0;
  always @(posedge aclk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a byte queue per line; words are cut every 4 bytes, {user,last,keep,data}.
  logic [7:0]  m_bytes[$];
  logic [37:0] m_exp[$];
  logic        m_user = 1'b0;
  logic [37:0] obs[$];
  bit          capture = 0;
  int unsigned n_words = 0, n_last = 0, n_user = 0;

  task automatic model_accept(input logic [23:0] p, input logic s, input logic e);
    logic [37:0] w;
    logic [31:0] d;
    logic [3:0]  k;
    if (s) begin
      m_bytes.delete();
      m_user = 1'b1;
    end
    m_bytes.push_back(p[7:0]);
    m_bytes.push_back(p[15:8]);
    m_bytes.push_back(p[23:16]);
    while (m_bytes.size() >= 4) begin
      d = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      for (int i = 0; i < 4; i++) void'(m_bytes.pop_front());
      m_exp.push_back({m_user, 1'b0, 4'hF, d});
      m_user = 1'b0;
    end
    if (e) begin
      if (m_bytes.size() > 0) begin
        d = '0;
        k = '0;
        for (int i = 0; i < m_bytes.size(); i++) begin
          d[8*i +: 8] = m_bytes[i];
          k[i] = 1'b1;
        end
        m_exp.push_back({m_user, 1'b1, k, d});
        m_user = 1'b0;
        m_bytes.delete();
      end else begin
        w = m_exp.pop_back();
        w[36] = 1'b1;
        m_exp.push_back(w);
      end
    end
  endtask

  logic [38:0] prev_out;
  bit          prev_stall = 0;

  always @(negedge aclk) begin
    logic [37:0] cur, ex;
    if (!aresetn) begin
      m_bytes.delete();
      m_exp.delete();
      m_user = 1'b0;
      prev_stall = 0;
    end else begin
      cur = {tuser, tlast, tkeep, tdata};
      if (prev_stall) check("stable", 64'({tvalid, cur}), 64'(prev_out));
      if (tvalid && tready) begin
        n_words++;
        if (tlast) n_last++;
        if (tuser) n_user++;
        if (capture) obs.push_back(cur);
        if (m_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", cur);
        end else begin
          ex = m_exp.pop_front();
          check("word", 64'(cur), 64'(ex));
        end
      end
      prev_stall = tvalid && !tready;
      prev_out   = {tvalid, cur};
      if (valid && ready) model_accept({r, g, b}, sof, eol);
    end
  end

  task automatic drive_idle();
    valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = '0; g = '0; b = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
  task automatic send_pixel(input logic [23:0] p, input logic s, input logic e);
    int unsigned n;
    {r, g, b} = p; sof = s; eol = e; valid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!ready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    @(posedge aclk);
    #1;
    drive_idle();
  endtask

  task automatic rand_traffic(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      {r, g, b} = 24'($urandom);
      valid  = ($urandom % 4) != 0;
      sof    = ($urandom % 20) == 0;
      eol    = ($urandom % 10) == 0;
      tready = ($urandom % 4) != 0;
      @(posedge aclk);
      #1;
    end
    drive_idle();
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic [23:0] pix;
    logic        s;
    logic        e;
    int unsigned nw;
    logic [37:0] w0;
    logic [37:0] w1;
  } vec_t;

  vec_t        tbl[15];
  logic [37:0] tbl_exp[$];
  int unsigned c0, guard;

  initial begin
    tbl[0]  = '{24'h010203, 1'b1, 1'b0, 0, 38'h0, 38'h0};
    tbl[1]  = '{24'h040506, 1'b0, 1'b0, 1, {1'b1, 1'b0, 4'hF, 32'h06010203}, 38'h0};
    tbl[2]  = '{24'h070809, 1'b0, 1'b0, 1, {1'b0, 1'b0, 4'hF, 32'h08090405}, 38'h0};
    tbl[3]  = '{24'h0A0B0C, 1'b0, 1'b1, 1, {1'b0, 1'b1, 4'hF, 32'h0A0B0C07}, 38'h0};
    tbl[4]  = '{24'h112233, 1'b0, 1'b0, 0, 38'h0, 38'h0};
    tbl[5]  = '{24'h445566, 1'b0, 1'b1, 2, {1'b0, 1'b0, 4'hF, 32'h66112233},
                                           {1'b0, 1'b1, 4'h3, 32'h00004455}};
    tbl[6]  = '{24'hDEADBE, 1'b0, 1'b1, 1, {1'b0, 1'b1, 4'h7, 32'h00DEADBE}, 38'h0};
    tbl[7]  = '{24'h123456, 1'b0, 1'b0, 0, 38'h0, 38'h0};
    tbl[8]  = '{24'h789ABC, 1'b0, 1'b0, 1, {1'b0, 1'b0, 4'hF, 32'hBC123456}, 38'h0};
    tbl[9]  = '{24'hDEF012, 1'b0, 1'b1, 2, {1'b0, 1'b0, 4'hF, 32'hF012789A},
                                           {1'b0, 1'b1, 4'h1, 32'h000000DE}};
    tbl[10] = '{24'h111111, 1'b0, 1'b0, 0, 38'h0, 38'h0};
    tbl[11] = '{24'h222222, 1'b0, 1'b0, 1, {1'b0, 1'b0, 4'hF, 32'h22111111}, 38'h0};
    tbl[12] = '{24'hAABBCC, 1'b1, 1'b0, 0, 38'h0, 38'h0};
    tbl[13] = '{24'h334455, 1'b0, 1'b1, 2, {1'b1, 1'b0, 4'hF, 32'h55AABBCC},
                                           {1'b0, 1'b1, 4'h3, 32'h00003344}};
    tbl[14] = '{24'h5A5A5A, 1'b1, 1'b1, 1, {1'b1, 1'b1, 4'h7, 32'h005A5A5A}, 38'h0};

    tready = 1'b1;
    drive_idle();
    aresetn = 1'b0;
    #23;
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_tkeep_last_user", 64'({tkeep, tlast, tuser}), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    #9;
    aresetn = 1'b1;
    #1;
    check("ready_before_edge", 64'(ready), 64'(0));
    @(posedge aclk);
    #1;
    check("ready_after_edge", 64'(ready), 64'(1));

    // Directed vectors, back-to-back with tready held high.
    obs.delete();
    capture = 1;
    foreach (tbl[i]) begin
      send_pixel(tbl[i].pix, tbl[i].s, tbl[i].e);
      if (tbl[i].nw > 0) tbl_exp.push_back(tbl[i].w0);
      if (tbl[i].nw > 1) tbl_exp.push_back(tbl[i].w1);
    end
    wait_cycles(10);
    capture = 0;
    check("tbl_count", 64'(obs.size()), 64'(tbl_exp.size()));
    foreach (tbl_exp[i]) begin
      if (i < obs.size()) check($sformatf("tbl_word%0d", i), 64'(obs[i]), 64'(tbl_exp[i]));
    end

    // Scaled frame: 3 lines of 64 pixels at full rate.
    n_words = 0; n_last = 0; n_user = 0;
    c0 = cyc;
    for (int unsigned ln = 0; ln < 3; ln++)
      for (int unsigned px = 0; px < 64; px++)
        send_pixel(24'($urandom), (ln == 0 && px == 0), (px == 63));
    check("frame_cycles", 64'(cyc - c0), 64'(192));
    wait_cycles(10);
    check("frame_words", 64'(n_words), 64'(144));
    check("frame_tlast", 64'(n_last), 64'(3));
    check("frame_tuser", 64'(n_user), 64'(1));

    // Backpressure: ready must drop once DEPTH-1 words are buffered.
    tready = 1'b0;
    valid = 1'b1;
    guard = 0;
    {r, g, b} = 24'($urandom);
    @(negedge aclk);
    while (ready && guard < 50) begin
      @(posedge aclk);
      #1;
      {r, g, b} = 24'($urandom);
      @(negedge aclk);
      guard++;
    end
    check("bp_ready_fell", 64'(ready), 64'(0));
    check("bp_buffered", 64'(m_exp.size()), 64'(DEPTH - 1));
    wait_cycles(8);
    check("bp_hold", 64'({ready, tvalid}), 64'(2'b01));
    drive_idle();
    tready = 1'b1;
    wait_cycles(10);
    check("bp_drained", 64'(m_exp.size()), 64'(0));

    // Random traffic, async reset mid-burst, then more random traffic.
    rand_traffic(1500);
    valid = 1'b1;
    tready = 1'b0;
    wait_cycles(3);
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'({tvalid, tdata}), 64'(0));
    check("mid_rst_ready", 64'(ready), 64'(0));
    wait_cycles(3);
    @(posedge aclk);
    #3;
    aresetn = 1'b1;
    drive_idle();
    tready = 1'b1;
    obs.delete();
    capture = 1;
    @(posedge aclk);
    #1;
    send_pixel(24'hC0FFEE, 1'b0, 1'b1);
    wait_cycles(6);
    capture = 0;
    check("post_rst_count", 64'(obs.size()), 64'(1));
    if (obs.size() > 0) check("post_rst_word", 64'(obs[0]), 64'({1'b0, 1'b1, 4'h7, 32'h00C0FFEE}));
    rand_traffic(1500);

    tready = 1'b1;
    guard = 0;
    while (m_exp.size() != 0 && guard < 200) begin
      wait_cycles(1);
      guard++;
    end
    check("final_drain", 64'(m_exp.size()), 64'(0));
    wait_cycles(3);
    check("final_idle", 64'(tvalid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
